// File: rtl/strip_pkg.sv
// rtl/strip_pkg.sv - shared constants, status codes and fixed strip geometry tables
package strip_pkg;

  localparam int NUM_STRIPS = 13;
  localparam int CANVAS_W   = 128;
  localparam int CANVAS_H   = 128;

  typedef enum logic [1:0] {
    STAT_OK        = 2'd0,
    STAT_BAD_ID    = 2'd1,
    STAT_NO_FIT    = 2'd2,
    STAT_BAD_WIDTH = 2'd3
  } status_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // Indexed directly by the 4-bit strip ID; entries 0, 14 and 15 are unused IDs.
  localparam logic [4:0] STRIP_HEIGHT [16] = '{
    5'd0,  5'd8,  5'd8,  5'd9,  5'd7,  5'd10, 5'd6,  5'd11,
    5'd5,  5'd12, 5'd4,  5'd16, 5'd16, 5'd16, 5'd0,  5'd0
  };

  localparam logic [7:0] STRIP_Y_ORIGIN [16] = '{
    8'd0,  8'd0,  8'd8,  8'd16, 8'd25, 8'd32, 8'd42, 8'd48,
    8'd59, 8'd64, 8'd76, 8'd80, 8'd96, 8'd112, 8'd0, 8'd0
  };

endpackage

// File: rtl/id_to_strip_geom.sv
// rtl/id_to_strip_geom.sv - combinational strip ID to height / y-origin decoder
module id_to_strip_geom
  import strip_pkg::*;
(
  input  logic [3:0] id,
  output logic [4:0] height,
  output logic [7:0] y_origin,
  output logic       id_valid
);

  assign id_valid = (id != 4'd0) && (id <= 4'(NUM_STRIPS));
  assign height   = id_valid ? STRIP_HEIGHT[id]   : 5'd0;
  assign y_origin = id_valid ? STRIP_Y_ORIGIN[id] : 8'd0;

endmodule

// File: rtl/strip_placer.sv
// rtl/strip_placer.sv - per-strip fill tracking and single-entry placement response register
module strip_placer
  import strip_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_strip_id_i,
  input  logic [4:0] req_width_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_x_o,
  output logic [7:0] rsp_y_o,
  output logic [4:0] rsp_h_o,
  output logic [1:0] rsp_status_o,
  output logic [7:0] placed_count_o
);

  logic [7:0] fill [NUM_STRIPS];
  logic [7:0] cur_fill;
  logic [8:0] fill_sum;
  logic [4:0] geom_h;
  logic [7:0] geom_y;
  logic       geom_ok;

  rsp_state_t state;
  status_t    rsp_status;
  status_t    nxt_status;
  logic [7:0] nxt_x;
  logic [7:0] nxt_y;
  logic [4:0] nxt_h;
  logic       accept;
  logic       place_ok;

  id_to_strip_geom u_geom (
    .id       (req_strip_id_i),
    .height   (geom_h),
    .y_origin (geom_y),
    .id_valid (geom_ok)
  );

  always_comb begin
    cur_fill = 8'd0;
    for (int i = 0; i < NUM_STRIPS; i++) begin
      if (req_strip_id_i == 4'(i + 1)) cur_fill = fill[i];
    end
  end

  // Nine bits so a full strip plus any width still compares correctly against the canvas.
  assign fill_sum = {1'b0, cur_fill} + {4'b0, req_width_i};

  always_comb begin
    nxt_status = STAT_OK;
    nxt_x      = cur_fill;
    nxt_y      = geom_y;
    nxt_h      = geom_h;
    if (!geom_ok) begin
      nxt_status = STAT_BAD_ID;
      nxt_x      = 8'd0;
      nxt_y      = 8'd0;
      nxt_h      = 5'd0;
    end else if (req_width_i == 5'd0) begin
      nxt_status = STAT_BAD_WIDTH;
    end else if (fill_sum > 9'(CANVAS_W)) begin
      nxt_status = STAT_NO_FIT;
    end
  end

  assign req_ready_o = !clear_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign place_ok    = accept && (nxt_status == STAT_OK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_STRIPS; i++) fill[i] <= 8'd0;
      placed_count_o <= 8'd0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_STRIPS; i++) fill[i] <= 8'd0;
      placed_count_o <= 8'd0;
    end else if (place_ok) begin
      for (int i = 0; i < NUM_STRIPS; i++) begin
        if (req_strip_id_i == 4'(i + 1)) fill[i] <= fill_sum[7:0];
      end
      if (placed_count_o != 8'hFF) placed_count_o <= placed_count_o + 8'd1;
    end
  end

  // Response register: payload only loads on acceptance, so it holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= RSP_EMPTY;
      rsp_status <= STAT_OK;
      rsp_x_o    <= 8'd0;
      rsp_y_o    <= 8'd0;
      rsp_h_o    <= 5'd0;
    end else begin
      case (state)
        RSP_EMPTY: if (accept) state <= RSP_FULL;
        RSP_FULL:  if (rsp_ready_i && !accept) state <= RSP_EMPTY;
        default:   state <= RSP_EMPTY;
      endcase
      if (accept) begin
        rsp_status <= nxt_status;
        rsp_x_o    <= nxt_x;
        rsp_y_o    <= nxt_y;
        rsp_h_o    <= nxt_h;
      end
    end
  end

  assign rsp_valid_o  = (state == RSP_FULL);
  assign rsp_status_o = rsp_status;

endmodule
